fetch_buffer: RTL

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 107 ++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// Instruction fetch front end: credit-limited request issue, in-order response tagging,
// a 2-entry {instr, pc} queue toward decode, and redirect flush with stale-response dropping.
module fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ir_valid,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  input  logic        ir_ready
);

  localparam logic [2:0] CREDITS = 3'(DEPTH);

  logic [31:0] r_pc;
  logic [1:0]  r_outstanding;
  logic [1:0]  r_drop;
  logic [1:0]  r_count;
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic        r_tag_rd;
  logic        r_tag_wr;
  logic [31:0] r_fifo_instr [2];
  logic [31:0] r_fifo_pc    [2];
  logic [31:0] r_tag_pc     [2];

  logic [2:0]  w_inflight;
  logic        w_fire;
  logic        w_rsp;
  logic        w_discard;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_outstanding_next;

  // Every granted request already owns a queue slot, so the queue can never overflow.
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_count};
  assign imem_req   = ~RST & ~redirect & (w_inflight < CREDITS);
  assign imem_addr  = r_pc;

  assign w_fire    = imem_req & imem_gnt;
  assign w_rsp     = imem_rvalid & (r_outstanding != 2'd0);
  assign w_discard = w_rsp & (r_drop != 2'd0);
  assign w_push    = w_rsp & ~w_discard & ~redirect;

  assign ir_valid = ~RST & (r_count != 2'd0);
  assign ir       = ir_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;
  assign ir_pc    = ir_valid ? r_fifo_pc[r_rd_ptr]    : 32'h0;
  assign w_pop    = ir_valid & ir_ready & ~redirect;

  assign w_outstanding_next = r_outstanding + {1'b0, w_fire} - {1'b0, w_rsp};

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      r_pc          <= RESET_PC;
      r_outstanding <= 2'd0;
      r_drop        <= 2'd0;
      r_count       <= 2'd0;
      r_rd_ptr      <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_tag_rd      <= 1'b0;
      r_tag_wr      <= 1'b0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (w_fire) r_tag_wr <= ~r_tag_wr;
      if (w_rsp)  r_tag_rd <= ~r_tag_rd;

      if (redirect) begin
        // Whatever is still in flight after this cycle belongs to the old stream.
        r_pc     <= redirect_pc & 32'hFFFF_FFFC;
        r_drop   <= w_outstanding_next;
        r_count  <= 2'd0;
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
      end else begin
        if (w_fire)    r_pc     <= r_pc + 32'd4;
        if (w_discard) r_drop   <= r_drop - 2'd1;
        if (w_push)    r_wr_ptr <= ~r_wr_ptr;
        if (w_pop)     r_rd_ptr <= ~r_rd_ptr;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // NOTE: storage arrays carry no reset; validity is tracked solely by the counts and pointers.
  always_ff @(posedge CLK) begin
    if (w_fire) r_tag_pc[r_tag_wr] <= r_pc;
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= imem_rdata;
      r_fifo_pc[r_wr_ptr]    <= r_tag_pc[r_tag_rd];
    end
  end

endmodule
